rr_arbiter_2x1: RTL

Two-input round-robin arbiter with a registered output stage. It sits directly upstream of the 2:1 data mux. It decides each cycle which of two valid/ready sources (A or B) may transfer, drives the mux select (sel=1 selects A, sel=0 selects B), and registers the selected word into a one-deep output slot. Bounded bursts guarantee that neither source can starve the other.

---
 rtl/rr_arbiter_2x1_if.sv | 26 ++
 rtl/rr_arbiter_2x1.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter_2x1_if.sv
// Handshake bundle for the 2:1 round-robin arbiter.
// Two valid/ready sources in, one registered valid/ready slot out.
interface rr_arbiter_2x1_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             sel;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready;

    modport master (
        output a_valid, a_data, b_valid, b_data, y_ready,
        input  a_ready, b_ready, sel, y_valid, y_data
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, y_ready,
        output a_ready, b_ready, sel, y_valid, y_data
    );
endinterface

// File: rtl/rr_arbiter_2x1.sv
// Two-input round-robin arbiter with bounded bursts
// and a one-deep registered output slot.
module rr_arbiter_2x1 #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    rr_arbiter_2x1_if.slave   bus
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic [3:0]       r_cnt;
    logic             r_y_valid;
    logic [WIDTH-1:0] r_y_data;
    logic             r_sel;

    logic             w_load;
    logic             w_both;
    logic             w_burst_done;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_fire;
    logic             w_same;
    logic             w_sel;

    assign w_load       = !r_y_valid || bus.y_ready;
    assign w_both       = bus.a_valid && bus.b_valid;
    assign w_burst_done = (r_cnt >= MAX_CNT);
    assign w_fire       = w_gnt_a || w_gnt_b;
    assign w_same       = (w_gnt_a && r_state == GRANT_A)
                       || (w_gnt_b && r_state == GRANT_B);

    // Grant decision: contention resolved by state and burst count
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!rst && w_load) begin
            if (w_both) begin
                unique case (r_state)
                    IDLE: begin
                        w_gnt_a = !r_last;
                        w_gnt_b = r_last;
                    end
                    GRANT_A: begin
                        w_gnt_a = !w_burst_done;
                        w_gnt_b = w_burst_done;
                    end
                    GRANT_B: begin
                        w_gnt_a = w_burst_done;
                        w_gnt_b = !w_burst_done;
                    end
                    default: begin
                        w_gnt_a = 1'b0;
                        w_gnt_b = 1'b0;
                    end
                endcase
            end else begin
                w_gnt_a = bus.a_valid;
                w_gnt_b = bus.b_valid;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: follows the granted source, idles on empty load
    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            if (w_gnt_a) begin
                w_state_nxt = GRANT_A;
            end else if (w_gnt_b) begin
                w_state_nxt = GRANT_B;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    // FSM outputs: readies and mux select; sel holds when no grant
    always_comb begin
        bus.a_ready = w_gnt_a;
        bus.b_ready = w_gnt_b;
        w_sel       = 1'b0;
        if (!rst) begin
            w_sel = w_fire ? w_gnt_a : r_sel;
        end
        bus.sel = w_sel;
    end

    // Output slot, burst counter, last-winner and held select
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_last    <= 1'b0;
            r_cnt     <= 4'd0;
            r_sel     <= 1'b0;
        end else begin
            r_sel <= w_sel;
            if (w_load) begin
                if (w_fire) begin
                    r_y_valid <= 1'b1;
                    r_y_data  <= w_gnt_a ? bus.a_data : bus.b_data;
                    r_last    <= w_gnt_a;
                    if (w_same) begin
                        r_cnt <= w_burst_done ? MAX_CNT : r_cnt + 4'd1;
                    end else begin
                        r_cnt <= 4'd1;
                    end
                end else begin
                    r_y_valid <= 1'b0;
                    r_cnt     <= 4'd0;
                end
            end
        end
    end

    assign bus.y_valid = r_y_valid;
    assign bus.y_data  = r_y_data;
endmodule
